// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus family: slave/master ports and arbiter.
package bus_pkg;

  // Default widths used across the bus family.
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  // Levels of the split handshake toward the arbiter.
  localparam logic SPLIT_REQ = 1'b1;  // release the bus while the slave is busy
  localparam logic SPLIT_REL = 1'b0;  // no split requested

  // Slave-port FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX      = 3'd1,
    ACCESS  = 3'd2,
    SPLIT   = 3'd3,
    WAIT_RD = 3'd4,
    VALID   = 3'd5,
    TX      = 3'd6
  } bus_state_e;

  // Latched request type.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_slave_port_split_if.sv
// Serial bus signals between the interconnect (master side) and one slave port.
//
// Handshake semantics: a request is latched from read_en/write_en only while
// slave_ready=1. Serial address/data bits transfer on every cycle where
// master_valid=1; master_valid=0 is a pause. Read data is offered with
// slave_valid=1; the first cycle where slave_valid=1 and master_ready=1 starts
// the serial read-out, which then runs to completion without further stalls.
interface bus_slave_port_split_if;
  logic read_en;
  logic write_en;
  logic master_valid;
  logic rx_address;
  logic rx_data;
  logic master_ready;
  logic slave_ready;
  logic slave_valid;
  logic tx_data;
  logic split_en;

  modport master (
    output read_en, write_en, master_valid, rx_address, rx_data, master_ready,
    input  slave_ready, slave_valid, tx_data, split_en
  );

  modport slave (
    input  read_en, write_en, master_valid, rx_address, rx_data, master_ready,
    output slave_ready, slave_valid, tx_data, split_en
  );
endinterface

// File: rtl/bus_serial_tx.sv
// Parallel-load, LSB-first serialiser. One bit per cycle after load; done
// marks the cycle carrying the last bit.
module bus_serial_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  sout
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Load a new word or shift out one bit per busy cycle.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = din;
      cnt_d   = FULL;
    end else if (busy) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q - ONE;
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == ONE);
  assign sout = busy & shreg_q[0];

endmodule

// File: rtl/bus_slave_port_split.sv
// Serial bus slave port: deserialises address/write data, strobes the slave
// memory, optionally splits the bus during slow reads, serialises read data.
module bus_slave_port_split
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SPLIT_CYCLES = 0,  // 0 disables the split window
  parameter int RD_LATENCY   = 1   // must be >= 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_slave_port_split_if.slave bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output bus_state_e            state_dbg
);

  localparam int RX_MAX = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W  = $clog2(RX_MAX + 1);
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int SPL_W  = (SPLIT_CYCLES > 0) ? $clog2(SPLIT_CYCLES + 1) : 1;

  // A write needs every address and data bit; a read only the address.
  localparam logic [CNT_W-1:0] RX_WR_BITS = CNT_W'(RX_MAX);
  localparam logic [CNT_W-1:0] RX_RD_BITS = CNT_W'(ADDR_WIDTH);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(RD_LATENCY);
  localparam logic [SPL_W-1:0] SPL_LAST   = SPL_W'(SPLIT_CYCLES);

  bus_state_e            state_q, state_d;
  bus_op_e               op_q, op_d;
  logic                  pend_q, pend_d;       // request latched, waiting for master_valid
  logic [CNT_W-1:0]      cnt_q, cnt_d;         // serial bits received so far
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]      lat_q, lat_d;         // cycles elapsed since mem_rd
  logic                  capt_q, capt_d;       // read data already captured
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SPL_W-1:0]      split_cnt_q, split_cnt_d;

  logic shift_en;
  logic track_rd;
  logic tx_load;
  logic tx_busy;
  logic tx_done;
  logic tx_bit;

  function automatic logic [CNT_W-1:0] rx_bits(input bus_op_e op);
    return (op == OP_WRITE) ? RX_WR_BITS : RX_RD_BITS;
  endfunction

  // Next-state and datapath updates for the whole transfer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    capt_d      = capt_q;
    rdata_d     = rdata_q;
    split_cnt_d = split_cnt_q;
    shift_en    = 1'b0;
    track_rd    = 1'b0;
    tx_load     = 1'b0;

    case (state_q)
      IDLE: begin
        // write_en has priority when both strobes arrive together.
        if (bus.write_en) begin
          op_d   = OP_WRITE;
          pend_d = 1'b1;
        end else if (bus.read_en) begin
          op_d   = OP_READ;
          pend_d = 1'b1;
        end
        // The first valid cycle already carries bit 0.
        if (pend_d && bus.master_valid) begin
          shift_en = 1'b1;
          pend_d   = 1'b0;
          cnt_d    = CNT_W'(1);
          state_d  = (rx_bits(op_d) == CNT_W'(1)) ? ACCESS : RX;
        end
      end
      RX: begin
        if (bus.master_valid) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == rx_bits(op_q)) state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = '0;
        if (op_q == OP_WRITE) begin
          state_d = IDLE;
        end else begin
          lat_d  = LAT_W'(1);
          capt_d = 1'b0;
          if (SPLIT_CYCLES > 0) begin
            state_d     = SPLIT;
            split_cnt_d = SPL_W'(1);
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      SPLIT: begin
        track_rd = 1'b1;
        if (split_cnt_q == SPL_LAST) state_d = WAIT_RD;
        else split_cnt_d = split_cnt_q + SPL_W'(1);
      end
      WAIT_RD: begin
        track_rd = 1'b1;
        if (capt_q || (lat_q == LAT_LAST)) state_d = VALID;
      end
      VALID: begin
        if (bus.master_ready) begin
          tx_load = 1'b1;
          state_d = TX;
        end
      end
      TX: begin
        if (tx_done) begin
          state_d     = IDLE;
          capt_d      = 1'b0;
          lat_d       = '0;
          split_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read latency runs from the mem_rd cycle and overlaps the split window.
    if (track_rd && !capt_q) begin
      if (lat_q == LAT_LAST) begin
        rdata_d = mem_rdata;
        capt_d  = 1'b1;
      end else begin
        lat_d = lat_q + LAT_W'(1);
      end
    end

    // Serial bit cnt lands at position cnt; bits past a field's width are dropped.
    if (shift_en) begin
      for (int i = 0; i < ADDR_WIDTH; i++) begin
        if (cnt_q == CNT_W'(i)) addr_d[i] = bus.rx_address;
      end
      if (op_d == OP_WRITE) begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) wdata_d[i] = bus.rx_data;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      capt_q      <= 1'b0;
      rdata_q     <= '0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      capt_q      <= capt_d;
      rdata_q     <= rdata_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  bus_serial_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .din   (rdata_q),
    .busy  (tx_busy),
    .done  (tx_done),
    .sout  (tx_bit)
  );

  assign bus.slave_ready = (state_q == IDLE);
  assign bus.slave_valid = (state_q == VALID) || (state_q == TX);
  assign bus.tx_data     = (state_q == TX) && tx_busy && tx_bit;
  assign bus.split_en    = (state_q == SPLIT) ? SPLIT_REQ : SPLIT_REL;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wr          = (state_q == ACCESS) && (op_q == OP_WRITE);
  assign mem_rd          = (state_q == ACCESS) && (op_q == OP_READ);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_bus_slave_port_split.sv
// Directed bench for bus_slave_port_split: unit 0 without split (latency 1),
// unit 1 with a 4-cycle split window and latency 2. sel picks the active unit.
module tb_bus_slave_port_split;
  import bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared stimulus ----------------
  logic       sel;
  logic       read_en, write_en, master_valid, rx_address, rx_data, master_ready;
  logic [7:0] mem_rdata;

  bus_slave_port_split_if bus0 ();
  bus_slave_port_split_if bus1 ();

  assign bus0.read_en      = read_en & ~sel;
  assign bus0.write_en     = write_en & ~sel;
  assign bus0.master_valid = master_valid & ~sel;
  assign bus0.rx_address   = rx_address;
  assign bus0.rx_data      = rx_data;
  assign bus0.master_ready = master_ready & ~sel;
  assign bus1.read_en      = read_en & sel;
  assign bus1.write_en     = write_en & sel;
  assign bus1.master_valid = master_valid & sel;
  assign bus1.rx_address   = rx_address;
  assign bus1.rx_data      = rx_data;
  assign bus1.master_ready = master_ready & sel;

  logic [11:0] mem_addr0, mem_addr1;
  logic [7:0]  mem_wdata0, mem_wdata1;
  logic        mem_wr0, mem_wr1, mem_rd0, mem_rd1;
  bus_state_e  st0, st1;

  bus_slave_port_split #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_CYCLES(0), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_wr(mem_wr0), .mem_rd(mem_rd0),
    .mem_rdata(mem_rdata), .state_dbg(st0)
  );

  bus_slave_port_split #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_CYCLES(4), .RD_LATENCY(2)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .mem_rd(mem_rd1),
    .mem_rdata(mem_rdata), .state_dbg(st1)
  );

  // Observed outputs of the selected unit.
  logic        o_slave_ready, o_slave_valid, o_tx_data, o_split_en, o_mem_wr, o_mem_rd;
  logic [11:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  bus_state_e  o_state;
  assign o_slave_ready = sel ? bus1.slave_ready : bus0.slave_ready;
  assign o_slave_valid = sel ? bus1.slave_valid : bus0.slave_valid;
  assign o_tx_data     = sel ? bus1.tx_data     : bus0.tx_data;
  assign o_split_en    = sel ? bus1.split_en    : bus0.split_en;
  assign o_mem_wr      = sel ? mem_wr1    : mem_wr0;
  assign o_mem_rd      = sel ? mem_rd1    : mem_rd0;
  assign o_mem_addr    = sel ? mem_addr1  : mem_addr0;
  assign o_mem_wdata   = sel ? mem_wdata1 : mem_wdata0;
  assign o_state       = sel ? st1 : st0;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, o_slave_ready, 1);
    check({tag, "_valid"}, o_slave_valid, 0);
    check({tag, "_txd"},   o_tx_data, 0);
    check({tag, "_split"}, o_split_en, 0);
    check({tag, "_wr"},    o_mem_wr, 0);
    check({tag, "_rd"},    o_mem_rd, 0);
    check({tag, "_addr"},  o_mem_addr, 0);
    check({tag, "_wdata"}, o_mem_wdata, 0);
    check({tag, "_state"}, 32'(o_state), 32'(IDLE));
  endtask

  // Drives 12 serial bits; optional master_valid gap before bit gap_at.
  task automatic send_bits(input logic [11:0] addr, input logic [7:0] data,
                           input int gap_at, input int gap_len);
    logic [11:0] dext;
    dext = {4'h0, data};
    for (int i = 0; i < 12; i++) begin
      if (i == gap_at) begin
        master_valid = 1'b0;
        repeat (gap_len) tick();
      end
      master_valid = 1'b1;
      rx_address   = addr[i];
      rx_data      = dext[i];
      tick();
      if (i == 0) check("rdy_drop", o_slave_ready, 0);
    end
    master_valid = 1'b0;
    rx_address   = 1'b0;
    rx_data      = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data,
                          input int gap_at, input int gap_len, input bit with_read);
    write_en = 1'b1;
    read_en  = with_read;
    tick();
    write_en = 1'b0;
    read_en  = 1'b0;
    send_bits(addr, data, gap_at, gap_len);
    check("wr_strobe", o_mem_wr, 1);
    check("wr_no_rd",  o_mem_rd, 0);
    check("wr_addr",   o_mem_addr, addr);
    check("wr_data",   o_mem_wdata, data);
    tick();
    check("wr_once",   o_mem_wr, 0);
    check("wr_rdy",    o_slave_ready, 1);
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [7:0] rdata,
                         input int exp_split, input int lat, input int ready_delay,
                         input bit drop_ready, input int abort_bit);
    int         k, v_cyc, n_split, first_split, last_split;
    bit         bp_ok;
    logic [7:0] got_byte;
    logic [0:0] exp_bit;
    master_ready = 1'b0;
    mem_rdata    = ~rdata;
    read_en      = 1'b1;
    tick();
    read_en = 1'b0;
    send_bits(addr, 8'h00, -1, 0);
    check("rd_strobe", o_mem_rd, 1);
    check("rd_no_wr",  o_mem_wr, 0);
    check("rd_addr",   o_mem_addr, addr);
    master_ready = (ready_delay == 0);
    // Memory returns the true word only exactly lat cycles after mem_rd.
    k = 0; v_cyc = 0; n_split = 0; first_split = 0; last_split = 0;
    while (v_cyc == 0 && k < 100) begin
      tick();
      k++;
      mem_rdata = (k == lat) ? rdata : (~rdata ^ 8'(k));
      if (o_split_en) begin
        n_split++;
        last_split = k;
        if (first_split == 0) first_split = k;
      end
      if (o_slave_valid) v_cyc = k;
    end
    if (v_cyc == 0) begin
      check("vld_timeout", 0, 1);
      return;
    end
    check("split_cnt", n_split, exp_split);
    if (exp_split > 0) check("split_start", first_split, 1);
    check("vld_after_split", (v_cyc > last_split), 1);
    if (exp_split == 0) check("vld_lat", v_cyc, lat + 1);
    // Back-pressure: valid held, data line low, until master_ready.
    bp_ok = 1'b1;
    for (int i = 0; i < ready_delay; i++) begin
      if (!(o_slave_valid && !o_tx_data && !o_slave_ready)) bp_ok = 1'b0;
      tick();
    end
    if (ready_delay > 0) check("bp_hold", (bp_ok && o_slave_valid && !o_tx_data), 1);
    master_ready = 1'b1;
    tick();
    for (int b = 0; b < 8; b++) exp_q.push_back(rdata[b]);
    got_byte = '0;
    for (int b = 0; b < 8; b++) begin
      if (drop_ready) master_ready = 1'b0;
      if (b == abort_bit) begin
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        master_ready = 1'b0;
        exp_q.delete();
        check_reset_state("abort");
        return;
      end
      check("tx_valid", o_slave_valid, 1);
      exp_bit = exp_q.pop_front();
      check("tx_bit", o_tx_data, exp_bit);
      got_byte[b] = o_tx_data;
      tick();
    end
    master_ready = 1'b0;
    check("tx_byte",     got_byte, rdata);
    check("tx_end_vld",  o_slave_valid, 0);
    check("tx_end_data", o_tx_data, 0);
    check("tx_end_rdy",  o_slave_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel = 1'b0; read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
    rx_address = 1'b0; rx_data = 1'b0; master_ready = 1'b0; mem_rdata = 8'h00;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_state("rst0");
    sel = 1'b1;
    check_reset_state("rst1");

    // Plain write.
    sel = 1'b0;
    do_write(12'hA5C, 8'h3E, -1, 0, 1'b0);
    // Read, no split, latency 1, master_ready held.
    do_read(12'h123, 8'h96, 0, 1, 0, 1'b0, -1);
    // Read with 4-cycle split and latency 2.
    sel = 1'b1;
    do_read(12'h7F1, 8'hC3, 4, 2, 0, 1'b0, -1);
    // Write with a 3-cycle master_valid gap mid-address.
    sel = 1'b0;
    do_write(12'h3C7, 8'h5A, 5, 3, 1'b0);
    // Both strobes at once: the write wins.
    do_write(12'h0F0, 8'hA7, -1, 0, 1'b1);
    // Read with 5 cycles of back-pressure; master_ready dropped during TX.
    do_read(12'h2B4, 8'h5B, 0, 1, 5, 1'b1, -1);
    // Reset while bit 3 is on the wire, then a normal write.
    do_read(12'h456, 8'hE9, 0, 1, 0, 1'b0, 3);
    do_write(12'h8D1, 8'h6C, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_port_split.md
Name: bus_slave_port_split

Overview:
- Parametrised successor of the serial bus slave port.
- Deserialises address and write data from the bus, and issues single-cycle read/write strobes to the attached slave memory.
- Serialises read data back to the master.
- Adds configurable address/data widths, a programmable split window that releases the bus during slow reads, and explicit read-data capture latency.
- Sits between the bus interconnect (arbiter/mux) and one slave memory.

Parameters:
- ADDR_WIDTH, 12, address bits received serially.
- DATA_WIDTH, 8, data bits per transfer (both directions).
- SPLIT_CYCLES, 0, cycles split_en is held after a read strobe; 0 disables split.
- RD_LATENCY, 1, cycles from mem_rd to valid mem_rdata; must be >=1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- read_en  in  1  read request strobe from bus decoder
- write_en  in  1  write request strobe from bus decoder
- master_valid  in  1  master driving serial address/data this cycle
- rx_address  in  1  serial address bit, LSB first
- rx_data  in  1  serial write-data bit, LSB first
- master_ready  in  1  master ready to accept read data
- slave_ready  out  1  port idle and able to accept a new request
- slave_valid  out  1  read data available / being shifted out
- tx_data  out  1  serial read-data bit, LSB first
- split_en  out  1  request the arbiter to split (release) the bus
- mem_addr  out  ADDR_WIDTH  captured address
- mem_wdata  out  DATA_WIDTH  captured write data
- mem_wr  out  1  one-cycle write strobe
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  DATA_WIDTH  read data from memory

Behaviour:
- Reset:
  - state=IDLE.
  - slave_ready=1.
  - slave_valid, split_en, tx_data, mem_wr, mem_rd = 0.
  - mem_addr, mem_wdata = 0.
  - Counters and latched op cleared.
  - Reset mid-transfer aborts with no memory strobe.
- Request latch (IDLE only):
  - read_en or write_en sets op; write_en wins if both are high in the same cycle.
  - Strobes outside IDLE are ignored.
- States: IDLE, RX, ACCESS, SPLIT, WAIT_RD, VALID, TX.
- IDLE -> RX:
  - Triggered when an op is latched and master_valid=1.
  - That same cycle samples bit 0; slave_ready drops the next cycle.
- RX:
  - Each cycle with master_valid=1 shifts rx_address into bit[cnt] and, for writes, rx_data into bit[cnt].
  - Cycles with master_valid=0 hold (no shift, no count).
  - Exits when cnt reaches max(ADDR_WIDTH, DATA_WIDTH for writes / ADDR_WIDTH for reads).
  - Address bits beyond ADDR_WIDTH are ignored.
- ACCESS: exactly one cycle.
  - Write: mem_wr=1 with stable mem_addr/mem_wdata, then IDLE.
  - Read: mem_rd=1, then SPLIT if SPLIT_CYCLES>0, else WAIT_RD.
- SPLIT:
  - split_en=1 for exactly SPLIT_CYCLES cycles, then WAIT_RD.
- WAIT_RD:
  - mem_rdata is latched exactly RD_LATENCY cycles after the mem_rd cycle, counted from ACCESS and overlapping SPLIT.
  - Leaves for VALID at the later of capture and end of split.
- VALID:
  - slave_valid=1; waits for master_ready=1.
  - On master_ready, moves to TX and drives bit 0 the next cycle.
- TX:
  - tx_data=bit[k] for k=0..DATA_WIDTH-1, one bit per cycle, with slave_valid=1.
  - master_ready deassertion does not stall once TX has started.
  - After the last bit: slave_valid=0, tx_data=0, return to IDLE.
- slave_ready=1 only in IDLE.
- Back-to-back: a new request is accepted the first IDLE cycle after a write or TX completes.
- Width rules: counters are sized to clog2(max(ADDR_WIDTH, DATA_WIDTH)+1); there is no wrap within a transfer.

Decomposition:
- Shared package bus_pkg holds:
  - State encoding enum.
  - Default ADDR_WIDTH/DATA_WIDTH constants, reused by master port and arbiter.
  - Split-handshake constants.
- One natural sub-module: bus_serial_tx, a DATA_WIDTH parallel-load LSB-first shifter with load/busy/done. It is reusable by the master port.
- Deserialisation stays inline.

Test Plan:
- Write, ADDR_WIDTH=12, DATA_WIDTH=8:
  - Stimulus: write_en pulse, 12 cycles of master_valid serialising addr 0xA5C and data 0x3E.
  - Expect: one mem_wr with mem_addr=0xA5C, mem_wdata=0x3E, then slave_ready=1 the next cycle.
- Read, SPLIT_CYCLES=0, RD_LATENCY=1:
  - Stimulus: addr 0x123, mem_rdata=0x96, master_ready held.
  - Expect: mem_rd pulse, split_en never high, slave_valid rises, tx_data=0,1,1,0,1,0,0,1 over 8 cycles, then slave_valid=0.
- Read, SPLIT_CYCLES=4, RD_LATENCY=2:
  - Expect: split_en high exactly 4 cycles after mem_rd; slave_valid rises only after split_en falls; transmitted byte equals mem_rdata sampled 2 cycles after mem_rd.
- master_valid gap during RX:
  - Stimulus: deassert master_valid for 3 cycles mid-address.
  - Expect: address still captured correctly; mem strobe delayed by 3 cycles.
- Contention and back-pressure:
  - Stimulus: read_en and write_en together, then master_ready held low 5 cycles during a read.
  - Expect: write performed; slave_valid held high with tx_data=0 until master_ready, then shifting starts.
- Reset mid-TX (bit 3):
  - Expect: next cycle all outputs at reset values; a subsequent write completes normally.
